// File: rtl/button_pio_debounced.sv
// rtl/button_pio_debounced.sv - debounced button/switch PIO with edge capture and interrupt
// Pins are synchronised, debounced per channel, edge-qualified and latched into sticky capture bits.
module button_pio_debounced #(
   parameter int WIDTH         = 4,
   parameter int CNT_W         = 20,
   parameter bit ACTIVE_LOW    = 1'b1,
   parameter int DEFAULT_LIMIT = 50000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);
   localparam logic [2:0] ADDR_DATA  = 3'd0;
   localparam logic [2:0] ADDR_RAW   = 3'd1;
   localparam logic [2:0] ADDR_MASK  = 3'd2;
   localparam logic [2:0] ADDR_CAP   = 3'd3;
   localparam logic [2:0] ADDR_MODE  = 3'd4;
   localparam logic [2:0] ADDR_LIMIT = 3'd5;

   localparam logic [2*WIDTH-1:0] MODE_RST  = {WIDTH{2'b01}};
   localparam logic [CNT_W-1:0]   LIMIT_RST = CNT_W'(DEFAULT_LIMIT);

   logic [WIDTH-1:0]   pin_norm;
   logic [WIDTH-1:0]   sync1_q, sync2_q;
   logic [WIDTH-1:0]   stb_q, stb_d, stb_prev_q;
   logic [CNT_W-1:0]   cnt_q [WIDTH];
   logic [CNT_W-1:0]   cnt_d [WIDTH];
   logic [WIDTH-1:0]   mask_q, mask_d;
   logic [WIDTH-1:0]   cap_q, cap_d;
   logic [2*WIDTH-1:0] mode_q, mode_d;
   logic [CNT_W-1:0]   limit_q, limit_d, limit_m1;
   logic [31:0]        readdata_q, readdata_d;
   logic [WIDTH-1:0]   rise, fall, qual_edge, w1c;
   logic               wr_en, wr_mask, wr_cap, wr_mode, wr_limit, bypass;
   logic               unused_wdata;

   // Normalise polarity so a pressed button is logical 1 from the first flop on.
   assign pin_norm = in_port ^ {WIDTH{ACTIVE_LOW}};

   assign wr_en    = chipselect & ~write_n;
   assign wr_mask  = wr_en && (address == ADDR_MASK);
   assign wr_cap   = wr_en && (address == ADDR_CAP);
   assign wr_mode  = wr_en && (address == ADDR_MODE);
   assign wr_limit = wr_en && (address == ADDR_LIMIT);

   assign unused_wdata = ^writedata;

   assign bypass   = (limit_q <= CNT_W'(1));
   assign limit_m1 = limit_q - CNT_W'(1);

   always_comb begin
      stb_d = stb_q;
      for (int n = 0; n < WIDTH; n++) begin
         cnt_d[n] = cnt_q[n];
         if (wr_limit) begin
            cnt_d[n] = '0;
         end else if (bypass) begin
            stb_d[n] = sync2_q[n];
            cnt_d[n] = '0;
         end else if (sync2_q[n] == stb_q[n]) begin
            cnt_d[n] = '0;
         end else if (cnt_q[n] >= limit_m1) begin
            stb_d[n] = sync2_q[n];
            cnt_d[n] = '0;
         end else begin
            cnt_d[n] = cnt_q[n] + CNT_W'(1);
         end
      end
   end

   assign rise = stb_q & ~stb_prev_q;
   assign fall = ~stb_q & stb_prev_q;

   always_comb begin
      qual_edge = '0;
      for (int n = 0; n < WIDTH; n++) begin
         qual_edge[n] = (rise[n] & mode_q[2*n]) | (fall[n] & mode_q[2*n+1]);
      end
   end

   // A fresh edge outranks a simultaneous clear so no press is ever dropped.
   assign w1c     = wr_cap ? writedata[WIDTH-1:0] : '0;
   assign cap_d   = (cap_q & ~w1c) | qual_edge;
   assign mask_d  = wr_mask  ? writedata[WIDTH-1:0]   : mask_q;
   assign mode_d  = wr_mode  ? writedata[2*WIDTH-1:0] : mode_q;
   assign limit_d = wr_limit ? writedata[CNT_W-1:0]   : limit_q;

   always_comb begin
      readdata_d = '0;
      case (address)
         ADDR_DATA:  readdata_d[WIDTH-1:0]   = stb_q;
         ADDR_RAW:   readdata_d[WIDTH-1:0]   = sync2_q;
         ADDR_MASK:  readdata_d[WIDTH-1:0]   = mask_q;
         ADDR_CAP:   readdata_d[WIDTH-1:0]   = cap_q;
         ADDR_MODE:  readdata_d[2*WIDTH-1:0] = mode_q;
         ADDR_LIMIT: readdata_d[CNT_W-1:0]   = limit_q;
         default:    readdata_d              = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         stb_q      <= '0;
         stb_prev_q <= '0;
         for (int n = 0; n < WIDTH; n++) begin
            cnt_q[n] <= '0;
         end
         mask_q     <= '0;
         cap_q      <= '0;
         mode_q     <= MODE_RST;
         limit_q    <= LIMIT_RST;
         readdata_q <= '0;
      end else begin
         sync1_q    <= pin_norm;
         sync2_q    <= sync1_q;
         stb_q      <= stb_d;
         stb_prev_q <= stb_q;
         for (int n = 0; n < WIDTH; n++) begin
            cnt_q[n] <= cnt_d[n];
         end
         mask_q     <= mask_d;
         cap_q      <= cap_d;
         mode_q     <= mode_d;
         limit_q    <= limit_d;
         readdata_q <= readdata_d;
      end
   end

   assign readdata = readdata_q;
   assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_button_pio_debounced.sv
// tb/tb_button_pio_debounced.sv - directed and randomized bench for button_pio_debounced
// Reference model predicts debounced levels from pin-change and limit-write timestamps.
module tb_button_pio_debounced;
   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [3:0]  in_port;
   logic [31:0] readdata;
   logic        irq;

   int errors = 0;
   int checks = 0;

   logic [3:0]  m_p1, m_s2, m_stb, m_flip, m_mask, m_cap;
   logic [7:0]  m_mode;
   logic [19:0] m_limit;
   logic [31:0] m_rd;
   int          edge_n = 0;
   int          chg [4];
   int          clr = 0;

   logic [31:0] exp_reset [8];

   button_pio_debounced #(
      .WIDTH(4), .CNT_W(20), .ACTIVE_LOW(1'b1), .DEFAULT_LIMIT(50000)
   ) dut (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(readdata), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Model: a channel's level adopts RAW once RAW has differed for LIMIT edges since
   // both its last change and the last limit write.
   task automatic tick();
      logic [3:0]  logical, qual, flip, w1c;
      logic [31:0] rd_n;
      int          t, lim, base;
      bit          wr;
      t       = edge_n + 1;
      logical = ~in_port;
      wr      = chipselect && !write_n;
      rd_n    = '0;
      case (address)
         3'd0: rd_n[3:0]  = m_stb;
         3'd1: rd_n[3:0]  = m_s2;
         3'd2: rd_n[3:0]  = m_mask;
         3'd3: rd_n[3:0]  = m_cap;
         3'd4: rd_n[7:0]  = m_mode;
         3'd5: rd_n[19:0] = m_limit;
         default: rd_n = '0;
      endcase
      qual = '0;
      for (int ch = 0; ch < 4; ch++) begin
         if (m_flip[ch]) qual[ch] = m_stb[ch] ? m_mode[2*ch] : m_mode[2*ch+1];
      end
      w1c  = (wr && address == 3'd3) ? writedata[3:0] : 4'h0;
      lim  = (m_limit <= 20'd1) ? 1 : int'(m_limit);
      flip = '0;
      for (int ch = 0; ch < 4; ch++) begin
         base = (chg[ch] > clr) ? chg[ch] : clr;
         if (!(wr && address == 3'd5) && m_s2[ch] != m_stb[ch] && t >= base + lim)
            flip[ch] = 1'b1;
      end
      @(posedge clk);
      edge_n = t;
      if (reset) begin
         m_p1 = '0; m_s2 = '0; m_stb = '0; m_flip = '0;
         m_mask = '0; m_cap = '0; m_mode = 8'h55; m_limit = 20'd50000; m_rd = '0;
         for (int ch = 0; ch < 4; ch++) chg[ch] = t;
         clr = t;
      end else begin
         m_rd   = rd_n;
         m_cap  = (m_cap & ~w1c) | qual;
         m_stb  = m_stb ^ flip;
         m_flip = flip;
         for (int ch = 0; ch < 4; ch++) begin
            if (m_p1[ch] != m_s2[ch]) chg[ch] = t;
         end
         m_s2 = m_p1;
         m_p1 = logical;
         if (wr) begin
            case (address)
               3'd2: m_mask = writedata[3:0];
               3'd4: m_mode = writedata[7:0];
               3'd5: begin m_limit = writedata[19:0]; clr = t; end
               default: ;
            endcase
         end
      end
      #1;
      check32("model_readdata", readdata, m_rd);
      check32("model_irq", {31'd0, irq}, {31'd0, |(m_cap & m_mask)});
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
      tick();
      chipselect = 1'b0; write_n = 1'b1; writedata = '0;
   endtask

   initial begin
      int pin_idx;
      exp_reset = '{32'd0, 32'd0, 32'd0, 32'd0, 32'h55, 32'd50000, 32'd0, 32'd0};
      reset = 1'b1; in_port = 4'hF; chipselect = 1'b0; write_n = 1'b1;
      address = 3'd0; writedata = '0;
      ticks(2);
      check32("reset_irq", {31'd0, irq}, 32'd0);
      reset = 1'b0;
      for (int a = 0; a < 8; a++) begin
         address = 3'(a);
         tick();
         check32("reset_read", readdata, exp_reset[a]);
      end
      ticks(5);
      address = 3'd3; tick();
      check32("reset_no_capture", readdata, 32'd0);

      // Debounce with LIMIT=8: level appears 8 edges after RAW
      bus_write(3'd5, 32'd8);
      address = 3'd0; in_port = 4'hE;
      ticks(10);
      check32("deb_not_yet", {31'd0, readdata[0]}, 32'd0);
      tick();
      check32("deb_level", {31'd0, readdata[0]}, 32'd1);
      ticks(9);
      in_port = 4'hF; ticks(12);
      address = 3'd3; tick();
      check32("deb_capture", readdata, 32'd1);
      in_port = 4'hD; ticks(5);
      in_port = 4'hF; ticks(15);
      address = 3'd0; tick();
      check32("glitch_level", {31'd0, readdata[1]}, 32'd0);
      address = 3'd3; tick();
      check32("glitch_capture", readdata, 32'd1);

      // Edge modes: ch3 both, ch2 falling, ch1 rising, ch0 off
      bus_write(3'd3, 32'hF);
      bus_write(3'd4, 32'hE4);
      bus_write(3'd5, 32'd2);
      in_port = 4'h0; ticks(8);
      address = 3'd3; tick();
      check32("mode_press", readdata, 32'b1010);
      in_port = 4'hF; ticks(8);
      address = 3'd3; tick();
      check32("mode_release", readdata, 32'b1110);

      // IRQ mask and W1C
      bus_write(3'd3, 32'hF);
      bus_write(3'd4, 32'h55);
      bus_write(3'd2, 32'h2);
      in_port = 4'hD; ticks(8);
      check32("irq_set", {31'd0, irq}, 32'd1);
      bus_write(3'd3, 32'h1);
      check32("irq_wrong_w1c", {31'd0, irq}, 32'd1);
      bus_write(3'd3, 32'h2);
      check32("irq_cleared", {31'd0, irq}, 32'd0);
      address = 3'd3; tick();
      check32("cap_cleared", readdata, 32'd0);
      in_port = 4'hF; ticks(8);

      // Capture edge coinciding with W1C of the same bit
      bus_write(3'd4, 32'h03);
      bus_write(3'd2, 32'h1);
      in_port = 4'hE; ticks(8);
      check32("sim_irq_pre", {31'd0, irq}, 32'd1);
      in_port = 4'hF; ticks(4);
      bus_write(3'd3, 32'h1);
      check32("sim_irq_kept", {31'd0, irq}, 32'd1);
      address = 3'd3; tick();
      check32("sim_cap_kept", {31'd0, readdata[0]}, 32'd1);
      bus_write(3'd3, 32'h1);
      check32("sim_irq_cleared", {31'd0, irq}, 32'd0);

      // Limit lowered mid-count restarts the count
      bus_write(3'd4, 32'h55);
      bus_write(3'd2, 32'h0);
      bus_write(3'd3, 32'hF);
      bus_write(3'd5, 32'd100);
      in_port = 4'hB; ticks(52);
      bus_write(3'd5, 32'd10);
      address = 3'd0; ticks(10);
      check32("limit_not_early", {31'd0, readdata[2]}, 32'd0);
      tick();
      check32("limit_update", {31'd0, readdata[2]}, 32'd1);

      // Reset with a pending interrupt and a count in flight
      bus_write(3'd2, 32'h4);
      check32("pre_reset_irq", {31'd0, irq}, 32'd1);
      bus_write(3'd5, 32'd50);
      in_port = 4'hF; ticks(10);
      reset = 1'b1; tick();
      check32("mid_reset_irq", {31'd0, irq}, 32'd0);
      tick();
      reset = 1'b0;
      for (int a = 0; a < 8; a++) begin
         address = 3'(a);
         tick();
         check32("post_reset_read", readdata, exp_reset[a]);
      end

      // Randomized traffic against the model
      bus_write(3'd5, 32'd3);
      bus_write(3'd4, 32'hFF);
      for (int i = 0; i < 800; i++) begin
         chipselect = ($urandom_range(0, 3) != 0);
         write_n    = ($urandom_range(0, 7) != 0);
         address    = 3'($urandom_range(0, 7));
         writedata  = $urandom;
         if (address == 3'd5) writedata = 32'($urandom_range(0, 5));
         if ($urandom_range(0, 4) == 0) begin
            pin_idx = $urandom_range(0, 3);
            in_port[pin_idx] = ~in_port[pin_idx];
         end
         tick();
      end
      chipselect = 1'b0; write_n = 1'b1;
      ticks(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
